// File: rtl/l1d_bus_hand.sv
// l1d_bus_hand: turns one L1D line refill/writeback into four single-beat TL-UL transactions.
// Optional D-channel watchdog: define L1D_BUS_TIMEOUT_EN.
module l1d_bus_hand #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  FSM_current_state,
  input  logic [31:0] Transform_aBitsData,
  input  logic [31:0] Transform_aBitsAddress,
  output logic        Bus_hand_DataRdBusCond,
  output logic        Bus_hand_DataWrtBusCond,
  output logic        Bus_hand_RW,
  output logic [31:0] Bus_hand_dBitsData,
  output logic        Bus_hand_Error,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [2:0]  a_opcode,
  output logic [31:0] a_address,
  output logic [31:0] a_data,
  output logic [3:0]  a_mask,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [2:0]  d_opcode,
  input  logic [31:0] d_data,
  input  logic        d_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_LOAD, S_CAP, S_A_REQ, S_D_WAIT, S_R_ACK, S_DONE
  } state_t;

  localparam logic [1:0] FSM_WRITE_BUS = 2'b01;
  localparam logic [1:0] FSM_READ_BUS  = 2'b10;
  localparam logic [2:0] OP_GET        = 3'd4;
  localparam logic [2:0] OP_PUT_FULL   = 3'd0;
  localparam logic [2:0] OP_ACK        = 3'd0;
  localparam logic [2:0] OP_ACK_DATA   = 3'd1;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        rw_q, rw_d;
  logic        err_q, err_d;
  logic [2:0]  a_opcode_q, a_opcode_d;
  logic [31:0] a_address_q, a_address_d;
  logic [31:0] a_data_q, a_data_d;
  logic [3:0]  a_mask_q, a_mask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tmo_hit;

`ifdef L1D_BUS_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  assign tmo_hit = (state_q == S_D_WAIT) && (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; the parameter stays referenced so both builds share one interface.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  assign Bus_hand_RW        = rw_q;
  assign Bus_hand_Error     = err_q;
  assign Bus_hand_dBitsData = rdata_q;
  assign a_opcode           = a_opcode_q;
  assign a_address          = a_address_q;
  assign a_data             = a_data_q;
  assign a_mask             = a_mask_q;

  always_comb begin
    state_d                 = state_q;
    beat_d                  = beat_q;
    rw_d                    = rw_q;
    err_d                   = err_q;
    a_opcode_d              = a_opcode_q;
    a_address_d             = a_address_q;
    a_data_d                = a_data_q;
    a_mask_d                = a_mask_q;
    rdata_d                 = rdata_q;
    a_valid                 = 1'b0;
    d_ready                 = 1'b0;
    Bus_hand_DataRdBusCond  = 1'b0;
    Bus_hand_DataWrtBusCond = 1'b0;
`ifdef L1D_BUS_TIMEOUT_EN
    tmo_d                   = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (FSM_current_state == FSM_READ_BUS) begin
          state_d = S_CAP;
          rw_d    = 1'b1;
          beat_d  = 2'd0;
          err_d   = 1'b0;
        end else if (FSM_current_state == FSM_WRITE_BUS) begin
          state_d = S_W_LOAD;
          rw_d    = 1'b0;
          beat_d  = 2'd0;
          err_d   = 1'b0;
        end
      end

      S_W_LOAD: begin
        Bus_hand_DataWrtBusCond = 1'b1;
        state_d                 = S_CAP;
      end

      S_CAP: begin
        a_address_d = Transform_aBitsAddress & ~32'h3;
        a_mask_d    = 4'hF;
        if (rw_q) begin
          a_opcode_d = OP_GET;
          a_data_d   = 32'h0;
        end else begin
          // The same strobe that captures word n shifts the transform to word n+1.
          a_opcode_d              = OP_PUT_FULL;
          a_data_d                = Transform_aBitsData;
          Bus_hand_DataWrtBusCond = 1'b1;
        end
        state_d = S_A_REQ;
      end

      S_A_REQ: begin
        a_valid = 1'b1;
        if (a_ready) begin
          state_d = S_D_WAIT;
`ifdef L1D_BUS_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end
      end

      S_D_WAIT: begin
        d_ready = !tmo_hit;
`ifdef L1D_BUS_TIMEOUT_EN
        tmo_d   = tmo_q + 8'd1;
`endif
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (d_valid) begin
          if (d_error || (d_opcode != (rw_q ? OP_ACK_DATA : OP_ACK))) begin
            err_d = 1'b1;
          end
          if (rw_q) begin
            rdata_d = d_data;
            state_d = S_R_ACK;
          end else if (beat_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = S_CAP;
          end
        end
      end

      S_R_ACK: begin
        Bus_hand_DataRdBusCond = 1'b1;
        if (beat_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = S_CAP;
        end
      end

      S_DONE: begin
        // Stay until the L1D FSM leaves the requesting state so one request yields one burst.
        if (FSM_current_state != (rw_q ? FSM_READ_BUS : FSM_WRITE_BUS)) begin
          state_d = S_IDLE;
          rw_d    = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= 2'd0;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
      a_opcode_q  <= 3'd0;
      a_address_q <= 32'h0;
      a_data_q    <= 32'h0;
      a_mask_q    <= 4'h0;
      rdata_q     <= 32'h0;
`ifdef L1D_BUS_TIMEOUT_EN
      tmo_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rw_q        <= rw_d;
      err_q       <= err_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      a_data_q    <= a_data_d;
      a_mask_q    <= a_mask_d;
      rdata_q     <= rdata_d;
`ifdef L1D_BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule
